uart_tx_arbiter: RTL and testbench

// Shares one UART byte transmitter between NUM_REQ byte-stream requesters using round-robin arbitration.

---
 rtl/uart_tx_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one UART byte transmitter
// between NUM_REQ byte-stream requesters. Each packet may be prefixed with a
// channel-ID header byte. Bytes go out one at a time over a start/busy handshake.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ       = 4,
   parameter bit          PREFIX_EN     = 1'b1,
   parameter int unsigned ACK_WAIT      = 4,
   parameter int unsigned STALL_TIMEOUT = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [NUM_REQ-1:0]     req_last,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_start,
   input  logic                   tx_busy,
   output logic [NUM_REQ-1:0]     grant,
   output logic                   active,
   output logic                   stall_err
);

   localparam int unsigned IdW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned AckW   = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;
   localparam int unsigned StallW = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;

   localparam logic [AckW-1:0]   AckLast   = AckW'((ACK_WAIT > 1) ? ACK_WAIT - 1 : 0);
   localparam logic [StallW-1:0] StallLast = StallW'((STALL_TIMEOUT > 0) ? STALL_TIMEOUT - 1 : 0);
   localparam logic [IdW-1:0]    IdMax     = IdW'(NUM_REQ - 1);

   typedef enum logic [2:0] {StIdle, StHdr, StLoad, StAck, StDone} state_e;

   state_e              state_q, state_d;
   logic [IdW-1:0]      ptr_q, ptr_d;
   logic [IdW-1:0]      id_q, id_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic                active_q, active_d;
   logic [7:0]          tx_data_q, tx_data_d;
   logic                tx_start_q, tx_start_d;
   logic                stall_err_q, stall_err_d;
   logic                last_q, last_d;
   logic [AckW-1:0]     ack_cnt_q, ack_cnt_d;
   logic [StallW-1:0]   stall_cnt_q, stall_cnt_d;

   logic                pick_found;
   logic [IdW-1:0]      pick_id;
   logic                owner_valid;
   logic                owner_last;
   logic [7:0]          owner_data;

   // (base + off) mod NUM_REQ, valid for off < NUM_REQ
   function automatic logic [IdW-1:0] rr_index(input logic [IdW-1:0] base,
                                               input int unsigned off);
      int unsigned sum;
      sum = 32'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return IdW'(sum);
   endfunction

   function automatic logic [IdW-1:0] wrap_inc(input logic [IdW-1:0] v);
      return (v == IdMax) ? '0 : v + 1'b1;
   endfunction

   // First valid requester scanning ptr, ptr+1, ... (wrapping)
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!pick_found && req_valid[rr_index(ptr_q, k)]) begin
            pick_found = 1'b1;
            pick_id    = rr_index(ptr_q, k);
         end
      end
   end

   // Select the current owner's byte-stream signals
   always_comb begin
      owner_valid = 1'b0;
      owner_last  = 1'b0;
      owner_data  = 8'h00;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (id_q == IdW'(i)) begin
            owner_valid = req_valid[i];
            owner_last  = req_last[i];
            owner_data  = req_data[8*i +: 8];
         end
      end
   end

   // Next-state and datapath updates for the packet FSM
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      grant_d     = grant_q;
      active_d    = active_q;
      tx_data_d   = tx_data_q;
      last_d      = last_q;
      tx_start_d  = 1'b0;
      stall_err_d = 1'b0;
      ack_cnt_d   = '0;
      // Stall count only survives consecutive idle cycles in StLoad
      stall_cnt_d = '0;

      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               id_d           = pick_id;
               grant_d        = '0;
               grant_d[pick_id] = 1'b1;
               active_d       = 1'b1;
               state_d        = PREFIX_EN ? StHdr : StLoad;
            end
         end

         StHdr: begin
            tx_data_d  = 8'hA0 | 8'(id_q);
            tx_start_d = 1'b1;
            last_d     = 1'b0;
            state_d    = StAck;
         end

         StLoad: begin
            if (owner_valid) begin
               tx_data_d  = owner_data;
               last_d     = owner_last;
               tx_start_d = 1'b1;
               state_d    = StAck;
            end else if (STALL_TIMEOUT != 0) begin
               if (stall_cnt_q == StallLast) begin
                  // Owner went quiet too long: drop the lock without sending
                  stall_err_d = 1'b1;
                  grant_d     = '0;
                  active_d    = 1'b0;
                  ptr_d       = wrap_inc(id_q);
                  state_d     = StIdle;
               end else begin
                  stall_cnt_d = stall_cnt_q + 1'b1;
               end
            end
         end

         StAck: begin
            // A transmitter that never raises busy is released by the timeout
            if (tx_busy || ack_cnt_q == AckLast) begin
               state_d = StDone;
            end else begin
               ack_cnt_d = ack_cnt_q + 1'b1;
            end
         end

         StDone: begin
            if (!tx_busy) begin
               if (last_q) begin
                  ptr_d    = wrap_inc(id_q);
                  grant_d  = '0;
                  active_d = 1'b0;
                  state_d  = StIdle;
               end else begin
                  state_d = StLoad;
               end
            end
         end

         default: state_d = StIdle;
      endcase
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         id_q        <= '0;
         grant_q     <= '0;
         active_q    <= 1'b0;
         tx_data_q   <= 8'h00;
         tx_start_q  <= 1'b0;
         stall_err_q <= 1'b0;
         last_q      <= 1'b0;
         ack_cnt_q   <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         grant_q     <= grant_d;
         active_q    <= active_d;
         tx_data_q   <= tx_data_d;
         tx_start_q  <= tx_start_d;
         stall_err_q <= stall_err_d;
         last_q      <= last_d;
         ack_cnt_q   <= ack_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Only the owner sees ready, and only while a byte slot is open
   always_comb begin
      req_ready = (state_q == StLoad) ? grant_q : '0;
   end

   assign tx_data   = tx_data_q;
   assign tx_start  = tx_start_q;
   assign grant     = grant_q;
   assign active    = active_q;
   assign stall_err = stall_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based requesters, a simple busy-pulse
// transmitter model, a tx_start logger, table-driven single-source packets and
// directed sequences for contention, fairness, handshake, no-ack, stall and reset.
module tb_uart_tx_arbiter;

   localparam int unsigned NUM_REQ = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    req_valid;
   logic [8*NUM_REQ-1:0]  req_data;
   logic [NUM_REQ-1:0]    req_last;
   logic [NUM_REQ-1:0]    req_ready;
   logic [7:0]            tx_data;
   logic                  tx_start;
   logic                  tx_busy;
   logic [NUM_REQ-1:0]    grant;
   logic                  active;
   logic                  stall_err;

   uart_tx_arbiter #(
      .NUM_REQ       (NUM_REQ),
      .PREFIX_EN     (1'b1),
      .ACK_WAIT      (4),
      .STALL_TIMEOUT (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .tx_busy   (tx_busy),
      .grant     (grant),
      .active    (active),
      .stall_err (stall_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Requester byte queues: {last, data}
   logic [8:0] mem [NUM_REQ][32];
   int         head [NUM_REQ];
   int         tail [NUM_REQ];

   // Transmitter model
   bit busy_mode = 1'b1;
   int busy_len  = 6;
   int pend      = 0;
   int busy_cnt  = 0;

   // tx_start log and protocol monitors
   logic [7:0] log_d [64];
   logic [3:0] log_g [64];
   int log_n     = 0;
   int viol      = 0;
   int cyc       = 0;
   int last_cyc  = 0;
   bit have_last = 1'b0;
   bit prev_start = 1'b0;
   int gap_min   = 1000000;
   int gap_max   = 0;

   typedef struct packed {
      logic [1:0]  src;
      logic [2:0]  nb;
      logic [31:0] b;
      logic [39:0] e;
      logic [3:0]  gnt;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int r, input logic [7:0] d, input logic l);
      mem[r][tail[r]] = {l, d};
      tail[r]++;
   endtask

   task automatic clear_log();
      log_n     = 0;
      have_last = 1'b0;
      gap_min   = 1000000;
      gap_max   = 0;
   endtask

   task automatic wait_done(input int n, input string name);
      int t;
      t = 0;
      while (!(log_n >= n && active == 1'b0) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20000) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: timeout, %0d starts seen, %0d required", name, log_n, n);
      end
   endtask

   task automatic wait_grant(input logic [3:0] g, input string name);
      int t;
      t = 0;
      while (grant !== g && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: timeout, grant %0b required %0b", name, grant, g);
      end
   endtask

   // Compare the logged tx_start sequence; entry k at bits [8k+:8] / [4k+:4]
   task automatic check_seq(input string name, input int n,
                            input logic [63:0] e_data, input logic [31:0] e_grant);
      check({name, " count"}, 64'(log_n), 64'(n));
      for (int k = 0; k < n && k < log_n; k++) begin
         check($sformatf("%s byte%0d", name, k), 64'(log_d[k]), 64'(e_data[k*8 +: 8]));
         check($sformatf("%s grant%0d", name, k), 64'(log_g[k]), 64'(e_grant[k*4 +: 4]));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) head[i] = tail[i];
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Requester drivers, transmitter model and tx_start monitor
   initial begin
      logic [NUM_REQ-1:0] hs;
      forever begin
         @(negedge clk);
         cyc++;
         hs = req_valid & req_ready;
         if (tx_start) begin
            if (log_n < 64) begin
               log_d[log_n] = tx_data;
               log_g[log_n] = grant;
            end
            log_n++;
            if (tx_busy || prev_start) viol++;
            if (have_last) begin
               if (cyc - last_cyc < gap_min) gap_min = cyc - last_cyc;
               if (cyc - last_cyc > gap_max) gap_max = cyc - last_cyc;
            end
            have_last = 1'b1;
            last_cyc  = cyc;
            if (busy_mode) pend = 2;
         end
         prev_start = tx_start;
         @(posedge clk);
         #1;
         for (int i = 0; i < NUM_REQ; i++) if (hs[i]) head[i]++;
         if (busy_cnt > 0) busy_cnt--;
         if (pend > 0) begin
            pend--;
            if (pend == 0) busy_cnt = busy_len;
         end
         tx_busy = (busy_cnt > 0);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (head[i] < tail[i]) begin
               req_valid[i]       = 1'b1;
               req_data[8*i +: 8] = mem[i][head[i]][7:0];
               req_last[i]        = mem[i][head[i]][8];
            end else begin
               req_valid[i]       = 1'b0;
               req_data[8*i +: 8] = 8'h00;
               req_last[i]        = 1'b0;
            end
         end
      end
   end

   initial begin
      int cnt;
      logic [31:0] eg;

      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      tx_busy   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end

      vecs[0] = '{src: 2'd0, nb: 3'd2, b: 32'h0000_4241, e: 40'h00_0042_41A0, gnt: 4'b0001};
      vecs[1] = '{src: 2'd3, nb: 3'd1, b: 32'h0000_007E, e: 40'h00_0000_7EA3, gnt: 4'b1000};
      vecs[2] = '{src: 2'd2, nb: 3'd3, b: 32'h0030_2010, e: 40'h00_3020_10A2, gnt: 4'b0100};
      vecs[3] = '{src: 2'd1, nb: 3'd2, b: 32'h0000_00FF, e: 40'h00_0000_FFA1, gnt: 4'b0010};

      repeat (3) @(negedge clk);
      check("reset tx_start", 64'(tx_start), 64'd0);
      check("reset tx_data", 64'(tx_data), 64'd0);
      check("reset grant", 64'(grant), 64'd0);
      check("reset active", 64'(active), 64'd0);
      check("reset stall_err", 64'(stall_err), 64'd0);
      check("reset req_ready", 64'(req_ready), 64'd0);
      rst = 1'b0;

      // Single-source packets from the table
      for (int v = 0; v < 4; v++) begin
         clear_log();
         for (int k = 0; k < int'(vecs[v].nb); k++)
            push(int'(vecs[v].src), vecs[v].b[k*8 +: 8], k == int'(vecs[v].nb) - 1);
         eg = '0;
         for (int k = 0; k <= int'(vecs[v].nb); k++) eg[k*4 +: 4] = vecs[v].gnt;
         wait_done(int'(vecs[v].nb) + 1, $sformatf("vec%0d", v));
         check_seq($sformatf("vec%0d", v), int'(vecs[v].nb) + 1, 64'(vecs[v].e), eg);
         @(negedge clk);
         check($sformatf("vec%0d grant after", v), 64'(grant), 64'd0);
         check($sformatf("vec%0d active after", v), 64'(active), 64'd0);
      end

      // Contention at ptr=0: whole req0 packet, then whole req2 packet
      do_reset();
      clear_log();
      push(0, 8'h11, 1'b0); push(0, 8'h12, 1'b1);
      push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b1);
      wait_done(6, "contention");
      check_seq("contention", 6, 64'h0000_2221_A212_11A0, 32'h0044_4111);

      // Fairness: req1 re-requests at once, waiting req3 goes first
      do_reset();
      clear_log();
      push(1, 8'h31, 1'b1); push(1, 8'h32, 1'b1);
      wait_grant(4'b0010, "fairness grant1");
      push(3, 8'h33, 1'b1);
      wait_done(6, "fairness");
      check_seq("fairness", 6, 64'h0000_32A1_33A3_31A1, 32'h0022_8822);

      // Slow transmitter: busy rises 2 cycles after start, lasts 1042 cycles
      clear_log();
      viol     = 0;
      busy_len = 1042;
      push(2, 8'hC3, 1'b0); push(2, 8'h3C, 1'b1);
      wait_done(3, "handshake");
      check_seq("handshake", 3, 64'h3C_C3A2, 32'h444);
      check("handshake violations", 64'(viol), 64'd0);
      busy_len = 6;

      // No acknowledge: busy stays low, ACK_WAIT fallback paces starts
      @(negedge clk);
      clear_log();
      busy_mode = 1'b0;
      push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b0); push(0, 8'h03, 1'b1);
      wait_done(4, "noack");
      check_seq("noack", 4, 64'h0302_01A0, 32'h1111);
      check("noack min gap", 64'(gap_min), 64'd6);
      check("noack max gap", 64'(gap_max), 64'd6);
      check("noack violations", 64'(viol), 64'd0);
      busy_mode = 1'b1;

      // Stall: owner sends one non-last byte then goes quiet
      do_reset();
      clear_log();
      push(1, 8'h51, 1'b0);
      cnt = 0;
      for (int t = 0; t < 2000 && stall_err !== 1'b1; t++) begin
         @(negedge clk);
         if (stall_err !== 1'b1 && req_ready[1] && !req_valid[1]) cnt++;
      end
      check("stall err pulse", 64'(stall_err), 64'd1);
      check("stall idle cycles", 64'(cnt), 64'd16);
      check("stall grant", 64'(grant), 64'd0);
      check("stall active", 64'(active), 64'd0);
      check("stall bytes sent", 64'(log_n), 64'd2);
      @(negedge clk);
      check("stall err one cycle", 64'(stall_err), 64'd0);

      // Pointer moved past the stalled owner: req2 beats req1
      clear_log();
      push(1, 8'h61, 1'b1);
      push(2, 8'h62, 1'b1);
      wait_done(4, "post-stall");
      check_seq("post-stall", 4, 64'h61A1_62A2, 32'h2244);

      // Reset in the middle of a packet
      clear_log();
      push(3, 8'h71, 1'b0); push(3, 8'h72, 1'b0); push(3, 8'h73, 1'b1);
      cnt = 0;
      while (log_n < 2 && cnt < 2000) begin
         @(negedge clk);
         cnt++;
      end
      check("midreset started", 64'(log_n >= 2), 64'd1);
      rst = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) head[i] = tail[i];
      @(negedge clk);
      check("midreset tx_start", 64'(tx_start), 64'd0);
      check("midreset tx_data", 64'(tx_data), 64'd0);
      check("midreset grant", 64'(grant), 64'd0);
      check("midreset active", 64'(active), 64'd0);
      check("midreset stall_err", 64'(stall_err), 64'd0);
      check("midreset req_ready", 64'(req_ready), 64'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("post-reset idle", 64'(active), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
